rsa_exp_scheduler: RTL and testbench
====================================

# rsa_exp_scheduler

Shared modular-exponentiation sequencer for the 8-bit RSA datapath. It arbitrates round-robin between an encrypt requester and a decrypt requester and runs right-to-left square-and-multiply on the granted operand with the matching key exponent. It returns the result with a requester tag. One exponentiation engine therefore serves both directions, instead of separate encrypt and decrypt engines.

## Interface
Parameters:
- N, 187: modulus; 8-bit, must be ≥ 2.
- E, 7: public exponent; 8-bit.
- D, 23: private exponent; 8-bit (E·D ≡ 1 mod φ(N)).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enc_valid  in  1  encrypt request valid.
- enc_data  in  8  plaintext operand.
- enc_ready  out  1  encrypt request accepted this cycle.
- dec_valid  in  1  decrypt request valid.
- dec_data  in  8  ciphertext operand.
- dec_ready  out  1  decrypt request accepted this cycle.
- out_valid  out  1  result valid.
- out_data  out  8  operand^exp mod N.
- out_id  out  1  result tag: 0 = encrypt, 1 = decrypt.
- out_ready  in  1  consumer accepts result.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: pointer = encrypt; all output registers 0; enc_ready = dec_ready = 0.
- IDLE: the grant is chosen combinationally.
  - With a single valid, that channel is granted.
  - With both valid, the channel named by the pointer is granted.
  - Only the granted channel's ready is high; this is the transfer cycle.
- On transfer:
  - base = operand mod N; exp = E (enc) or D (dec); result = 1 mod N; cnt = 0; tag latched.
  - Pointer moves to the other channel.
  - Next state is RUN.
- RUN, each cycle:
  - If exp[0] = 1, result = (result·base) mod N.
  - base = (base·base) mod N; exp >>= 1; cnt++.
  - After the cycle with cnt = 7, next state is DONE.
- Arithmetic:
  - Products use the full 16 bits; reduction is mod N on the 16-bit value.
  - All stored values are < N.
  - Operands ≥ N are reduced on capture, not rejected.
- DONE:
  - out_valid = 1; out_data and out_id are held stable.
  - When out_ready = 1, next state is IDLE and out_valid drops the following cycle.
  - out_data holds its last value after the drop.
- Requester rules: valid and data must stay stable until ready. The block never asserts ready outside IDLE.
- The pointer changes only on a transfer. A channel still valid after being served loses to a pending other channel.

## Timing
- Transfer at edge ending cycle T. RUN occupies cycles T+1..T+8. out_valid is high from cycle T+9.
- Latency from transfer to out_valid is 9 cycles (default build).
- DONE lasts at least 1 cycle. If out_ready is high in T+9, state is IDLE in T+10, and a new transfer is possible in T+10.
- Minimum initiation interval is 10 cycles.
- Back-pressure: DONE holds indefinitely while out_ready = 0.
- Reset mid-RUN or mid-DONE:
  - The operation is aborted and its result is discarded; it is never presented.
  - State returns to IDLE and the pointer returns to encrypt on the next cycle.
- Simultaneous valid on reset release: encrypt is granted first.

## Configuration
- RSA_SCHED_EARLY_EXIT_EN:
  - Defined: RUN leaves for DONE after the cycle in which the shifted exp becomes 0, i.e. after bitlength(exp) cycles. A zero exponent takes 1 RUN cycle and the result is 1 mod N. Latency becomes 1 + max(1, bitlength(exp)) cycles; with the defaults that is 4 for encrypt and 6 for decrypt.
  - Undefined: always 8 RUN cycles; latency is fixed at 9.
  - Result values are identical in both builds.

## Test plan
- Reset, then enc_data = 88 → enc_ready pulses once; out_valid in T+9 with out_data = 11, out_id = 0 (T+4 with EARLY_EXIT).
- dec_data = 11 → out_data = 88, out_id = 1; round trip over all operands 0..186 returns the original value.
- enc_valid and dec_valid both high from reset with operands 88 and 11 → encrypt served first, then decrypt; then with both held, grants alternate enc, dec, enc.
- out_ready held low 20 cycles in DONE → out_valid and out_data stable, both readies low throughout; out_ready pulse → IDLE next cycle, new grant the cycle after.
- rst asserted in RUN cycle 4 → no out_valid for that job; IDLE next cycle; a fresh request gives a correct result.
- enc_data = 200 (≥ N) → treated as 13; out_data = 13^7 mod 187 = 106.

Source files
------------

// File: rtl/rsa_exp_scheduler.sv
// rsa_exp_scheduler: round-robin encrypt/decrypt arbiter in front of one right-to-left
// square-and-multiply engine. Define RSA_SCHED_EARLY_EXIT_EN to leave RUN once exp runs out.
module rsa_exp_scheduler #(
    parameter int N = 187,
    parameter int E = 7,
    parameter int D = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_valid,
    input  logic [7:0] enc_data,
    output logic       enc_ready,
    input  logic       dec_valid,
    input  logic [7:0] dec_data,
    output logic       dec_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_id,
    input  logic       out_ready,
    output logic       busy
);
    localparam logic [15:0] MOD16   = 16'(N);
    localparam logic [7:0]  MOD8    = 8'(N);
    localparam logic [7:0]  EXP_E   = 8'(E);
    localparam logic [7:0]  EXP_D   = 8'(D);
    localparam logic [7:0]  ONE_MOD = 8'd1 % MOD8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [7:0] base_q, base_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] res_q, res_d;
    logic [2:0] cnt_q, cnt_d;
    logic       id_q, id_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_id_q, out_id_d;

    logic       gnt_dec;
    logic       run_last;
    logic [7:0] exp_shift;
    logic [7:0] res_step;

    function automatic logic [7:0] mod_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        return 8'(p % MOD16);
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        base_d     = base_q;
        exp_d      = exp_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        enc_ready  = 1'b0;
        dec_ready  = 1'b0;

        // Decrypt wins only when alone or when the pointer names it.
        gnt_dec   = dec_valid && (!enc_valid || ptr_q);
        exp_shift = exp_q >> 1;
        res_step  = exp_q[0] ? mod_mul(res_q, base_q) : res_q;
`ifdef RSA_SCHED_EARLY_EXIT_EN
        run_last  = (exp_shift == 8'd0);
`else
        run_last  = (cnt_q == 3'd7);
`endif

        case (state_q)
            IDLE: begin
                if (!rst && (enc_valid || dec_valid)) begin
                    enc_ready = !gnt_dec;
                    dec_ready = gnt_dec;
                    base_d    = (gnt_dec ? dec_data : enc_data) % MOD8;
                    exp_d     = gnt_dec ? EXP_D : EXP_E;
                    res_d     = ONE_MOD;
                    cnt_d     = 3'd0;
                    id_d      = gnt_dec;
                    ptr_d     = !gnt_dec;
                    state_d   = RUN;
                end
            end
            RUN: begin
                res_d  = res_step;
                base_d = mod_mul(base_q, base_q);
                exp_d  = exp_shift;
                cnt_d  = cnt_q + 3'd1;
                if (run_last) begin
                    state_d    = DONE;
                    out_data_d = res_step;
                    out_id_d   = id_q;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            out_data_q <= 8'd0;
            out_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
        end
    end

    // Working registers are only meaningful in RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        base_q <= base_d;
        exp_q  <= exp_d;
        res_q  <= res_d;
        cnt_q  <= cnt_d;
        id_q   <= id_d;
    end

    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rsa_exp_scheduler.sv
// Scoreboard bench for rsa_exp_scheduler: transfers push expected results, a monitor pops them.
module tb_rsa_exp_scheduler;
    localparam int N = 187;
    localparam int E = 7;
    localparam int D = 23;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enc_valid = 1'b0;
    logic [7:0] enc_data = 8'd0;
    logic       enc_ready;
    logic       dec_valid = 1'b0;
    logic [7:0] dec_data = 8'd0;
    logic       dec_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_id;
    logic       out_ready;
    logic       busy;

    logic ordy_drv = 1'b1;
    logic rnd_ordy = 1'b0;
    logic rnd_val  = 1'b1;
    assign out_ready = rnd_ordy ? rnd_val : ordy_drv;

    rsa_exp_scheduler #(.N(N), .E(E), .D(D)) dut (
        .clk(clk), .rst(rst),
        .enc_valid(enc_valid), .enc_data(enc_data), .enc_ready(enc_ready),
        .dec_valid(dec_valid), .dec_data(dec_data), .dec_ready(dec_ready),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_val = ($urandom_range(0, 3) != 0);
    end

    typedef struct {
        logic       id;
        int         data;
        int         due;
    } exp_t;

    exp_t sbq[$];
    int   glog[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic void chk(string name, int act, int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endfunction

    function automatic void fail(string name);
        total_cnt++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endfunction

    // Reference: plain repeated multiplication, operand reduced first.
    function automatic int modexp(int b, int e);
        int r;
        int bb;
        r  = 1 % N;
        bb = b % N;
        for (int i = 0; i < e; i++) r = (r * bb) % N;
        return r;
    endfunction

    function automatic int lat(int e);
`ifdef RSA_SCHED_EARLY_EXIT_EN
        int bl;
        bl = 0;
        while (e > 0) begin
            bl++;
            e = e >> 1;
        end
        return 1 + ((bl < 1) ? 1 : bl);
`else
        return 9 + (e & 0);
`endif
    endfunction

    logic       mptr = 1'b0;
    logic       mon_g;
    logic       prev_ov = 1'b0;
    logic       prev_ordy = 1'b0;
    logic [7:0] prev_od = 8'd0;
    logic       prev_oid = 1'b0;
    exp_t       e_pop;

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            mptr    = 1'b0;
            prev_ov = 1'b0;
            chk("rst_enc_ready", enc_ready, 0);
            chk("rst_dec_ready", dec_ready, 0);
        end else begin
            if (!busy) begin
                if (enc_valid || dec_valid) begin
                    mon_g = (enc_valid && dec_valid) ? mptr : dec_valid;
                    chk("grant_enc_ready", enc_ready, !mon_g);
                    chk("grant_dec_ready", dec_ready, mon_g);
                    sbq.push_back('{mon_g,
                                    modexp(mon_g ? int'(dec_data) : int'(enc_data), mon_g ? D : E),
                                    cyc + lat(mon_g ? D : E)});
                    mptr = !mon_g;
                    if (enc_valid && enc_ready) glog.push_back(0);
                    if (dec_valid && dec_ready) glog.push_back(1);
                end else begin
                    chk("idle_enc_ready", enc_ready, 0);
                    chk("idle_dec_ready", dec_ready, 0);
                end
            end else begin
                chk("busy_enc_ready", enc_ready, 0);
                chk("busy_dec_ready", dec_ready, 0);
            end

            if (prev_ov && prev_ordy) begin
                chk("valid_drop", out_valid, 0);
                chk("data_hold_after_drop", out_data, prev_od);
            end else if (prev_ov) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_od);
                chk("stall_id", out_id, prev_oid);
            end else if (out_valid) begin
                chk("sb_depth", sbq.size(), 1);
                if (sbq.size() > 0) begin
                    e_pop = sbq.pop_front();
                    chk("out_data", out_data, e_pop.data);
                    chk("out_id", out_id, e_pop.id);
                    chk("latency_cycle", cyc, e_pop.due);
                end
            end
            prev_ov   = out_valid;
            prev_ordy = out_ready;
            prev_od   = out_data;
            prev_oid  = out_id;
        end
    end

    task automatic drive(input bit do_e, input logic [7:0] de, input bit do_d, input logic [7:0] dd);
        bit se;
        bit sd;
        int k;
        @(posedge clk);
        #1;
        if (do_e) begin enc_valid = 1'b1; enc_data = de; end
        if (do_d) begin dec_valid = 1'b1; dec_data = dd; end
        se = !do_e;
        sd = !do_d;
        k  = 0;
        while (!(se && sd) && k < 300) begin
            @(negedge clk);
            if (enc_valid && enc_ready) se = 1'b1;
            if (dec_valid && dec_ready) sd = 1'b1;
            @(posedge clk);
            #1;
            if (se) enc_valid = 1'b0;
            if (sd) dec_valid = 1'b0;
            k++;
        end
        if (!(se && sd)) begin
            fail("drive_timeout");
            enc_valid = 1'b0;
            dec_valid = 1'b0;
        end
    endtask

    task automatic wait_out(output logic [7:0] d, output logic id);
        int k;
        k = 0;
        d = 8'd0;
        id = 1'b0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 200);
        if (out_valid) begin
            d  = out_data;
            id = out_id;
        end else begin
            fail("wait_out_timeout");
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || out_valid || sbq.size() != 0) && k < 400);
        if (busy || out_valid || sbq.size() != 0) fail("wait_idle_timeout");
    endtask

    logic [7:0] rd;
    logic       rid;
    logic [7:0] cval;
    int         k0;
    int         mode;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_id", out_id, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        drive(1'b1, 8'd88, 1'b0, 8'd0);
        wait_out(rd, rid);
        chk("enc88_data", rd, 11);
        chk("enc88_id", rid, 0);

        drive(1'b0, 8'd0, 1'b1, 8'd11);
        wait_out(rd, rid);
        chk("dec11_data", rd, 88);
        chk("dec11_id", rid, 1);

        for (int x = 0; x < N; x++) begin
            drive(1'b1, 8'(x), 1'b0, 8'd0);
            wait_out(cval, rid);
            drive(1'b0, 8'd0, 1'b1, cval);
            wait_out(rd, rid);
            chk("round_trip", rd, x);
        end
        wait_idle();

        // Both requesters valid out of reset and held across several grants.
        @(posedge clk);
        #1;
        rst = 1'b1;
        glog.delete();
        enc_valid = 1'b1; enc_data = 8'd88;
        dec_valid = 1'b1; dec_data = 8'd11;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        k0 = 0;
        while (glog.size() < 3 && k0 < 100) begin
            @(negedge clk);
            k0++;
        end
        @(posedge clk);
        #1;
        enc_valid = 1'b0;
        dec_valid = 1'b0;
        if (glog.size() >= 3) begin
            chk("grant_order_0", glog[0], 0);
            chk("grant_order_1", glog[1], 1);
            chk("grant_order_2", glog[2], 0);
        end else begin
            fail("grant_order_timeout");
        end
        wait_idle();

        // Back-pressure with a competing request held during the stall.
        ordy_drv = 1'b0;
        drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'd0);
        wait_out(rd, rid);
        @(posedge clk);
        #1;
        enc_valid = 1'b1;
        enc_data  = 8'd88;
        repeat (20) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, rd);
        end
        @(posedge clk);
        #1 ordy_drv = 1'b1;
        @(posedge clk);
        #1 ordy_drv = 1'b0;
        @(negedge clk);
        chk("bp_idle_valid", out_valid, 0);
        chk("bp_regrant", enc_ready, 1);
        @(posedge clk);
        #1 enc_valid = 1'b0;
        ordy_drv = 1'b1;
        wait_idle();

        // Reset in the fourth RUN cycle aborts the job.
        drive(1'b0, 8'd0, 1'b1, 8'($urandom_range(0, 255)));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        repeat (15) begin
            @(negedge clk);
            chk("abort_no_out", out_valid, 0);
        end
        drive(1'b1, 8'd88, 1'b0, 8'd0);
        wait_out(rd, rid);
        chk("after_abort_data", rd, 11);

        drive(1'b1, 8'd200, 1'b0, 8'd0);
        wait_out(rd, rid);
        chk("enc200_data", rd, 106);
        wait_idle();

        // Random mix with random consumer back-pressure.
        rnd_ordy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 2);
            drive(mode != 1, 8'($urandom_range(0, 255)), mode != 0, 8'($urandom_range(0, 255)));
        end
        rnd_ordy = 1'b0;
        ordy_drv = 1'b1;
        wait_idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
